// File: rtl/wb_hash_initiator.sv
// wb_hash_initiator: Wishbone classic master sequencing an external hash core through init/update/finish
module wb_hash_initiator #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int TIMEOUT = 255
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [7:0]   cmd_blocklen,
  input  logic         blk_wr_en,
  input  logic [3:0]   blk_wr_idx,
  input  logic [31:0]  blk_wr_data,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [255:0] dig_data,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i
);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [2:0] {IDLE, WR_BLK, WR_LEN, WR_CTRL, POLL, RD_DIG, DONE, ERR} state_t;
  state_t state, state_d;
  logic gap;
  logic [3:0] idx;
  logic [CW-1:0] wcnt;
  logic [1:0] op;
  logic [7:0] len;
  logic [7:0] rn;
  logic [31:0] blk_mem [16];
  logic on_bus, ack_ok, tmo;
  assign on_bus = state inside {WR_BLK, WR_LEN, WR_CTRL, POLL, RD_DIG};
  assign wbm_cyc_o = on_bus & ~gap;
  assign wbm_stb_o = on_bus & ~gap;
  assign ack_ok = wbm_stb_o & wbm_ack_i;
  assign tmo = wbm_stb_o & ~wbm_ack_i & (wcnt == CW'(TIMEOUT));
  assign busy = state != IDLE;
  assign cmd_ready = ~busy;
  assign done = state == DONE;
  assign err = state == ERR;
  assign wbm_we_o = wbm_stb_o & (state inside {WR_BLK, WR_LEN, WR_CTRL});
  assign wbm_sel_o = wbm_stb_o ? 4'hF : 4'h0;
  assign wbm_adr_o = wbm_stb_o ? (BASE_ADDR | {8'h00, rn, 16'h0000}) : 32'h0;
  assign wbm_dat_o = ~wbm_we_o ? 32'h0 : state == WR_BLK ? blk_mem[idx] :
                     state == WR_LEN ? {24'h0, len} : {29'h0, op == 2'b10, op == 2'b01, op == 2'b00};
  // register number placed in adr[23:16] for the current transaction
  always_comb begin
    rn = state == WR_BLK ? {4'h1, idx} : state == WR_LEN ? 8'h0a : state == WR_CTRL ? 8'h08 :
         state == POLL ? 8'h09 : {5'b01000, idx[2:0]};
  end
  // next-state logic; a wait-counter expiry overrides every bus state
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cmd_valid) state_d = cmd_op == 2'b00 ? WR_CTRL : cmd_op == 2'b11 ? ERR : WR_BLK;
      WR_BLK:  if (ack_ok && idx == 4'hf) state_d = op == 2'b10 ? WR_LEN : WR_CTRL;
      WR_LEN:  if (ack_ok) state_d = WR_CTRL;
      WR_CTRL: if (ack_ok) state_d = POLL;
      POLL:    if (ack_ok && wbm_dat_i[0]) state_d = op == 2'b10 ? RD_DIG : DONE;
      RD_DIG:  if (ack_ok && idx == 4'h7) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (tmo) state_d = ERR;
  end
  // state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else state <= state_d;
  end
  // transaction bookkeeping: idle gap after each ack, word index, ack wait counter, latched command, digest capture
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      gap <= 1'b0;
      idx <= '0;
      wcnt <= '0;
      op <= '0;
      len <= '0;
      dig_data <= '0;
    end else begin
      gap <= ack_ok;
      idx <= state_d != state ? 4'h0 : idx + 4'(ack_ok);
      wcnt <= (wbm_stb_o & ~wbm_ack_i & ~tmo) ? wcnt + CW'(1) : '0;
      if (state == IDLE && cmd_valid) begin
        op <= cmd_op;
        len <= cmd_blocklen;
      end
      if (state == RD_DIG && ack_ok)
        for (int k = 0; k < 8; k++)
          if (idx[2:0] == 3'(k)) dig_data[255-32*k -: 32] <= wbm_dat_i;
    end
  end
  // local block buffer, frozen while a command is in flight
  always_ff @(posedge wb_clk_i) begin
    if (blk_wr_en && !busy) blk_mem[blk_wr_idx] <= blk_wr_data;
  end
endmodule
